// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, 32x32 register file, sign extension,
// load-use hazard detection and the ID/EX pipeline register. Optional macro: ID_WB_BYPASS_EN.
module id_stage (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [31:0] IF_ID_NEXT_ADR,
   input  logic [31:0] IF_ID_INS,
   input  logic        WB_REG_WRITE,
   input  logic [4:0]  WB_WRITE_REG,
   input  logic [31:0] WB_WRITE_DATA,
   input  logic        FLUSH,
   output logic        STALL_OUT,
   output logic [31:0] ID_EX_NEXT_ADR,
   output logic [31:0] ID_EX_READ_DATA_1,
   output logic [31:0] ID_EX_READ_DATA_2,
   output logic [31:0] ID_EX_SIGN_EXT_IMM,
   output logic [4:0]  ID_EX_RS,
   output logic [4:0]  ID_EX_RT,
   output logic [4:0]  ID_EX_RD,
   output logic [1:0]  ID_EX_ALU_OP,
   output logic        ID_EX_REG_DST,
   output logic        ID_EX_ALU_SRC,
   output logic        ID_EX_MEM_READ,
   output logic        ID_EX_MEM_WRITE,
   output logic        ID_EX_MEM_TO_REG,
   output logic        ID_EX_REG_WRITE,
   output logic        ID_EX_BRANCH
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] sign_ext_imm;

   assign opcode       = IF_ID_INS[31:26];
   assign rs           = IF_ID_INS[25:21];
   assign rt           = IF_ID_INS[20:16];
   assign rd           = IF_ID_INS[15:11];
   assign imm          = IF_ID_INS[15:0];
   assign sign_ext_imm = {{16{imm[15]}}, imm};

   logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [1:0] alu_op;

   always_comb begin
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      alu_op     = 2'b00;
      case (opcode)
         OP_RTYPE: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            alu_op    = 2'b10;
         end
         OP_LW: begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
         end
         OP_SW: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
         end
         OP_BEQ: begin
            branch = 1'b1;
            alu_op = 2'b01;
         end
         OP_ADDI: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   logic [31:0] regs [32];
   logic        wb_active;

   assign wb_active = WB_REG_WRITE && (WB_WRITE_REG != 5'd0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_active) begin
         regs[WB_WRITE_REG] <= WB_WRITE_DATA;
      end
   end

   logic [31:0] read_data_1, read_data_2;

`ifdef ID_WB_BYPASS_EN
   assign read_data_1 = (wb_active && WB_WRITE_REG == rs) ? WB_WRITE_DATA : regs[rs];
   assign read_data_2 = (wb_active && WB_WRITE_REG == rt) ? WB_WRITE_DATA : regs[rt];
`else
   assign read_data_1 = regs[rs];
   assign read_data_2 = regs[rt];
`endif

   // A load in EX whose destination feeds this instruction needs one bubble.
   logic hazard, bubble;

   assign hazard    = ID_EX_MEM_READ && (ID_EX_RT != 5'd0) &&
                      ((ID_EX_RT == rs) || (ID_EX_RT == rt));
   assign STALL_OUT = hazard && !FLUSH;
   assign bubble    = FLUSH || hazard;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N || bubble) begin
         ID_EX_NEXT_ADR     <= 32'd0;
         ID_EX_READ_DATA_1  <= 32'd0;
         ID_EX_READ_DATA_2  <= 32'd0;
         ID_EX_SIGN_EXT_IMM <= 32'd0;
         ID_EX_RS           <= 5'd0;
         ID_EX_RT           <= 5'd0;
         ID_EX_RD           <= 5'd0;
         ID_EX_ALU_OP       <= 2'b00;
         ID_EX_REG_DST      <= 1'b0;
         ID_EX_ALU_SRC      <= 1'b0;
         ID_EX_MEM_READ     <= 1'b0;
         ID_EX_MEM_WRITE    <= 1'b0;
         ID_EX_MEM_TO_REG   <= 1'b0;
         ID_EX_REG_WRITE    <= 1'b0;
         ID_EX_BRANCH       <= 1'b0;
      end else begin
         ID_EX_NEXT_ADR     <= IF_ID_NEXT_ADR;
         ID_EX_READ_DATA_1  <= read_data_1;
         ID_EX_READ_DATA_2  <= read_data_2;
         ID_EX_SIGN_EXT_IMM <= sign_ext_imm;
         ID_EX_RS           <= rs;
         ID_EX_RT           <= rt;
         ID_EX_RD           <= rd;
         ID_EX_ALU_OP       <= alu_op;
         ID_EX_REG_DST      <= reg_dst;
         ID_EX_ALU_SRC      <= alu_src;
         ID_EX_MEM_READ     <= mem_read;
         ID_EX_MEM_WRITE    <= mem_write;
         ID_EX_MEM_TO_REG   <= mem_to_reg;
         ID_EX_REG_WRITE    <= reg_write;
         ID_EX_BRANCH       <= branch;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode classes, register file, load-use stall,
// flush priority and the WB bypass option.
module tb_id_stage;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] IF_ID_NEXT_ADR;
   logic [31:0] IF_ID_INS;
   logic        WB_REG_WRITE;
   logic [4:0]  WB_WRITE_REG;
   logic [31:0] WB_WRITE_DATA;
   logic        FLUSH;
   logic        STALL_OUT;
   logic [31:0] ID_EX_NEXT_ADR, ID_EX_READ_DATA_1, ID_EX_READ_DATA_2, ID_EX_SIGN_EXT_IMM;
   logic [4:0]  ID_EX_RS, ID_EX_RT, ID_EX_RD;
   logic [1:0]  ID_EX_ALU_OP;
   logic        ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_READ, ID_EX_MEM_WRITE;
   logic        ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_BRANCH;

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] NOP = 32'hFC00_0000;

   always #5 CLK = ~CLK;

   id_stage dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .IF_ID_NEXT_ADR(IF_ID_NEXT_ADR), .IF_ID_INS(IF_ID_INS),
      .WB_REG_WRITE(WB_REG_WRITE), .WB_WRITE_REG(WB_WRITE_REG), .WB_WRITE_DATA(WB_WRITE_DATA),
      .FLUSH(FLUSH), .STALL_OUT(STALL_OUT),
      .ID_EX_NEXT_ADR(ID_EX_NEXT_ADR), .ID_EX_READ_DATA_1(ID_EX_READ_DATA_1),
      .ID_EX_READ_DATA_2(ID_EX_READ_DATA_2), .ID_EX_SIGN_EXT_IMM(ID_EX_SIGN_EXT_IMM),
      .ID_EX_RS(ID_EX_RS), .ID_EX_RT(ID_EX_RT), .ID_EX_RD(ID_EX_RD),
      .ID_EX_ALU_OP(ID_EX_ALU_OP), .ID_EX_REG_DST(ID_EX_REG_DST), .ID_EX_ALU_SRC(ID_EX_ALU_SRC),
      .ID_EX_MEM_READ(ID_EX_MEM_READ), .ID_EX_MEM_WRITE(ID_EX_MEM_WRITE),
      .ID_EX_MEM_TO_REG(ID_EX_MEM_TO_REG), .ID_EX_REG_WRITE(ID_EX_REG_WRITE),
      .ID_EX_BRANCH(ID_EX_BRANCH)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] adr);
      IF_ID_INS      = ins;
      IF_ID_NEXT_ADR = adr;
   endtask

   task automatic wb_write(input logic [4:0] idx, input logic [31:0] data);
      issue(NOP, 32'd0);
      WB_REG_WRITE  = 1'b1;
      WB_WRITE_REG  = idx;
      WB_WRITE_DATA = data;
      tick();
      WB_REG_WRITE  = 1'b0;
      WB_WRITE_REG  = 5'd0;
      WB_WRITE_DATA = 32'd0;
   endtask

   task automatic test_reset();
      checks++;
      if ({ID_EX_REG_WRITE, ID_EX_ALU_OP, ID_EX_RD, STALL_OUT} !== 9'd0) begin
         failures++;
         $display("FAIL power_on_reset got=%h want=0", {ID_EX_REG_WRITE, ID_EX_ALU_OP, ID_EX_RD, STALL_OUT});
      end
      @(negedge CLK) RESET_N = 1'b1;
      wb_write(5'd5, 32'h0000_AAAA);
      issue(32'h2004_FFFE, 32'h0000_0044);
      tick();
      #2;
      RESET_N = 1'b0;
      #1;
      checks++;
      if (ID_EX_SIGN_EXT_IMM !== 32'd0 || ID_EX_NEXT_ADR !== 32'd0) begin
         failures++;
         $display("FAIL async_reset_data imm=%h adr=%h want=0", ID_EX_SIGN_EXT_IMM, ID_EX_NEXT_ADR);
      end
      checks++;
      if ({ID_EX_ALU_SRC, ID_EX_REG_WRITE, ID_EX_RT, STALL_OUT} !== 8'd0) begin
         failures++;
         $display("FAIL async_reset_ctrl got=%h want=0", {ID_EX_ALU_SRC, ID_EX_REG_WRITE, ID_EX_RT, STALL_OUT});
      end
      @(negedge CLK) RESET_N = 1'b1;
      issue(32'h20A7_0000, 32'd0);   // addi $7,$5,0
      tick();
      checks++;
      if (ID_EX_READ_DATA_1 !== 32'd0) begin
         failures++;
         $display("FAIL reset_clears_r5 got=%h want=00000000", ID_EX_READ_DATA_1);
      end
   endtask

   task automatic test_rtype();
      wb_write(5'd1, 32'h0000_0005);
      wb_write(5'd2, 32'h0000_0007);
      issue(32'h0022_1820, 32'h0000_0100);   // add $3,$1,$2
      tick();
      checks++;
      if (ID_EX_READ_DATA_1 !== 32'd5 || ID_EX_READ_DATA_2 !== 32'd7) begin
         failures++;
         $display("FAIL rtype_reads got=%h,%h want=5,7", ID_EX_READ_DATA_1, ID_EX_READ_DATA_2);
      end
      checks++;
      if ({ID_EX_RS, ID_EX_RT, ID_EX_RD} !== {5'd1, 5'd2, 5'd3}) begin
         failures++;
         $display("FAIL rtype_idx got=%0d,%0d,%0d want=1,2,3", ID_EX_RS, ID_EX_RT, ID_EX_RD);
      end
      checks++;
      if ({ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ,
           ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP} !== 9'b1_0_0_1_0_0_0_10) begin
         failures++;
         $display("FAIL rtype_ctrl got=%b want=100100010", {ID_EX_REG_DST, ID_EX_ALU_SRC,
                  ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP});
      end
      checks++;
      if (ID_EX_NEXT_ADR !== 32'h0000_0100) begin
         failures++;
         $display("FAIL rtype_next_adr got=%h want=00000100", ID_EX_NEXT_ADR);
      end
   endtask

   task automatic test_immediate();
      issue(32'h2004_FFFE, 32'h0000_0104);   // addi $4,$0,-2
      tick();
      checks++;
      if (ID_EX_SIGN_EXT_IMM !== 32'hFFFF_FFFE || ID_EX_READ_DATA_1 !== 32'd0) begin
         failures++;
         $display("FAIL addi_data imm=%h rd1=%h want=fffffffe,0", ID_EX_SIGN_EXT_IMM, ID_EX_READ_DATA_1);
      end
      checks++;
      if ({ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ,
           ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP} !== 9'b0_1_0_1_0_0_0_00) begin
         failures++;
         $display("FAIL addi_ctrl got=%b want=010100000", {ID_EX_REG_DST, ID_EX_ALU_SRC,
                  ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP});
      end
      wb_write(5'd0, 32'h0000_DEAD);
      issue(32'h2004_0000, 32'd0);   // addi $4,$0,0
      tick();
      checks++;
      if (ID_EX_READ_DATA_1 !== 32'd0) begin
         failures++;
         $display("FAIL r0_write_ignored got=%h want=00000000", ID_EX_READ_DATA_1);
      end
   endtask

   task automatic test_other_decode();
      issue(32'hAC22_0004, 32'd0);   // sw $2,4($1)
      tick();
      checks++;
      if ({ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ,
           ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP} !== 9'b0_1_0_0_0_1_0_00) begin
         failures++;
         $display("FAIL sw_ctrl got=%b want=010001000", {ID_EX_REG_DST, ID_EX_ALU_SRC,
                  ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP});
      end
      issue(32'h1022_FFFF, 32'd0);   // beq $1,$2,-1
      tick();
      checks++;
      if ({ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ,
           ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP} !== 9'b0_0_0_0_0_0_1_01 ||
          ID_EX_SIGN_EXT_IMM !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL beq_decode ctrl=%b imm=%h want=000000101,ffffffff", {ID_EX_REG_DST, ID_EX_ALU_SRC,
                  ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH,
                  ID_EX_ALU_OP}, ID_EX_SIGN_EXT_IMM);
      end
      issue(32'hFC22_7FFF, 32'd0);   // unknown opcode
      tick();
      checks++;
      if ({ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ,
           ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP} !== 9'd0) begin
         failures++;
         $display("FAIL unknown_op_ctrl got=%b want=000000000", {ID_EX_REG_DST, ID_EX_ALU_SRC,
                  ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_ALU_OP});
      end
   endtask

   task automatic test_load_use();
      issue(32'h8C22_0000, 32'h0000_0200);   // lw $2,0($1)
      tick();
      checks++;
      if (ID_EX_MEM_READ !== 1'b1 || ID_EX_MEM_TO_REG !== 1'b1 || ID_EX_RT !== 5'd2) begin
         failures++;
         $display("FAIL lw_decode mr=%b m2r=%b rt=%0d want=1,1,2", ID_EX_MEM_READ, ID_EX_MEM_TO_REG, ID_EX_RT);
      end
      issue(32'h0042_1820, 32'h0000_0204);   // add $3,$2,$2
      #1;
      checks++;
      if (STALL_OUT !== 1'b1) begin
         failures++;
         $display("FAIL load_use_stall got=%b want=1", STALL_OUT);
      end
      tick();
      checks++;
      if ({ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_RD, ID_EX_RT, ID_EX_NEXT_ADR} !== 48'd0) begin
         failures++;
         $display("FAIL load_use_bubble rw=%b rt=%0d adr=%h want=0", ID_EX_REG_WRITE, ID_EX_RT, ID_EX_NEXT_ADR);
      end
      checks++;
      if (STALL_OUT !== 1'b0) begin
         failures++;
         $display("FAIL stall_one_cycle got=%b want=0", STALL_OUT);
      end
      tick();
      checks++;
      if (ID_EX_RD !== 5'd3 || ID_EX_REG_WRITE !== 1'b1 || ID_EX_NEXT_ADR !== 32'h0000_0204) begin
         failures++;
         $display("FAIL held_add_decodes rd=%0d rw=%b adr=%h want=3,1,00000204", ID_EX_RD, ID_EX_REG_WRITE, ID_EX_NEXT_ADR);
      end
   endtask

   task automatic test_flush();
      issue(32'h8C22_0000, 32'h0000_0300);   // lw $2,0($1)
      tick();
      issue(32'h0042_1820, 32'h0000_0304);
      FLUSH = 1'b1;
      #1;
      checks++;
      if (STALL_OUT !== 1'b0) begin
         failures++;
         $display("FAIL flush_masks_stall got=%b want=0", STALL_OUT);
      end
      tick();
      FLUSH = 1'b0;
      checks++;
      if ({ID_EX_REG_WRITE, ID_EX_REG_DST, ID_EX_ALU_OP, ID_EX_RD, ID_EX_RS,
           ID_EX_READ_DATA_1, ID_EX_NEXT_ADR} !== 78'd0) begin
         failures++;
         $display("FAIL flush_bubble rw=%b rd=%0d rd1=%h adr=%h want=0", ID_EX_REG_WRITE, ID_EX_RD,
                  ID_EX_READ_DATA_1, ID_EX_NEXT_ADR);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp;
`ifdef ID_WB_BYPASS_EN
      exp = 32'h1234_5678;
`else
      exp = 32'h0000_0000;
`endif
      issue(32'h20C7_0000, 32'd0);   // addi $7,$6,0
      WB_REG_WRITE  = 1'b1;
      WB_WRITE_REG  = 5'd6;
      WB_WRITE_DATA = 32'h1234_5678;
      tick();
      WB_REG_WRITE  = 1'b0;
      WB_WRITE_REG  = 5'd0;
      WB_WRITE_DATA = 32'd0;
      checks++;
      if (ID_EX_READ_DATA_1 !== exp) begin
         failures++;
         $display("FAIL same_cycle_wb got=%h want=%h", ID_EX_READ_DATA_1, exp);
      end
      tick();
      checks++;
      if (ID_EX_READ_DATA_1 !== 32'h1234_5678) begin
         failures++;
         $display("FAIL wb_visible_next got=%h want=12345678", ID_EX_READ_DATA_1);
      end
   endtask

   initial begin
      RESET_N        = 1'b0;
      IF_ID_INS      = NOP;
      IF_ID_NEXT_ADR = 32'd0;
      WB_REG_WRITE   = 1'b0;
      WB_WRITE_REG   = 5'd0;
      WB_WRITE_DATA  = 32'd0;
      FLUSH          = 1'b0;
      #1;
      test_reset();
      test_rtype();
      test_immediate();
      test_other_decode();
      test_load_use();
      test_flush();
      test_bypass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
